conv_tap_scheduler: RTL and testbench
=====================================

Name: conv_tap_scheduler

Overview:
- Sequencing controller for the 2x2 PE systolic convolution datapath: 4x4 input tile, 3x3 kernel, 2x2 output tile.
- On a start request it clears the PE accumulators, then steps through the kernel taps one per cycle. For each tap it emits the kernel index and the input-window offsets that the operand muxes use to drive the PE left/up inputs.
- It waits a fixed pipeline drain, then holds the result behind a valid/ready handshake.
- It sits between the tile loader (start/abort) and the consumer of c11..c22 (out_valid/out_ready).

Parameters:
- KDIM, 3, kernel side length; legal range 2..4. Taps per tile = KDIM*KDIM.
- PIPE_LAT, 1, cycles from the last enabled PE cycle to a stable PE output; legal range 0..3.
- FLIP, 1, 1 = true convolution (kernel reversed against the window); 0 = correlation.

Ports:
- clk  input  1  clock, rising-edge.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  request one tile computation.
- abort  input  1  synchronous cancel of the tile in flight.
- busy  output  1  high in every state except IDLE.
- pe_clr  output  1  synchronous accumulator clear to all PEs.
- pe_en  output  1  PE accumulate enable.
- tap_k  output  4  linear kernel tap index, 0..KDIM*KDIM-1.
- tap_i  output  2  kernel row of the current tap.
- tap_j  output  2  kernel column of the current tap.
- win_r  output  2  input row offset for PE(1,1); PE(r,c) uses win_r+r-1, win_c+c-1.
- win_c  output  2  input column offset for PE(1,1).
- out_valid  output  1  PE outputs c11..c22 hold the finished tile.
- out_ready  input  1  consumer accepts the tile.
- done  output  1  one-cycle pulse on tile acceptance.

Behaviour:
- Outputs are registered; there are no combinational paths from inputs to outputs.
- Reset values: state=IDLE; busy, pe_clr, pe_en, out_valid, done = 0; tap_k, tap_i, tap_j, win_r, win_c = 0.
- States: IDLE, CLEAR, FEED, DRAIN, HOLD.
- IDLE:
  - start=1 at an edge -> CLEAR.
  - start is ignored in every other state.
- CLEAR (1 cycle):
  - pe_clr=1, pe_en=0.
  - Taps load tap_k=0, tap_i=0, tap_j=0 for the following FEED cycle.
  - -> FEED.
- FEED (KDIM*KDIM cycles):
  - pe_en=1.
  - tap_j increments each cycle. It wraps to 0 at KDIM-1, and tap_i increments on that wrap.
  - tap_k = tap_i*KDIM + tap_j.
  - FLIP=1: win_r = KDIM-1-tap_i, win_c = KDIM-1-tap_j. FLIP=0: win_r = tap_i, win_c = tap_j.
  - After the tap with tap_k = KDIM*KDIM-1: -> DRAIN if PIPE_LAT>0, else -> HOLD.
- DRAIN (PIPE_LAT cycles):
  - pe_en=0.
  - Tap outputs hold their last value.
  - Drain counter runs 0..PIPE_LAT-1, then -> HOLD.
- HOLD:
  - out_valid=1 until a cycle with out_valid & out_ready.
  - In that cycle: done pulses high for the next cycle and out_valid drops.
  - -> IDLE, or -> CLEAR directly if start=1 in the handshake cycle (back-to-back tiles, no idle bubble).
- Latency, KDIM=3, PIPE_LAT=1, start seen at edge N:
  - pe_clr during cycle N+1.
  - pe_en during cycles N+2..N+10.
  - Drain in cycle N+11.
  - out_valid from cycle N+12.
- abort:
  - From any non-IDLE state -> IDLE at the next edge.
  - pe_en, pe_clr, out_valid drop; no done pulse.
  - abort has priority over start and over the out_ready handshake in the same cycle.
  - abort in IDLE: no effect.
- out_ready held high throughout: out_valid is asserted for exactly one cycle.
- out_ready asserted outside HOLD: ignored.
- rst mid-tile: immediately forces the reset values. The next tile needs a fresh start.

Test Plan:
- Basic tile, KDIM=3, PIPE_LAT=1, FLIP=1, out_ready=1: pulse start at edge 0 -> pe_clr in cycle 1; pe_en in cycles 2..10 with tap_k 0..8 and (win_r,win_c) = (2,2),(2,1),(2,0),(1,2)..(0,0); out_valid in cycle 12 only; done in cycle 13.
- Backpressure: out_ready=0 for 5 cycles after out_valid rises -> out_valid holds 5 cycles; tap outputs stay stable; done follows the first out_ready=1 cycle.
- Back-to-back: start=1 during the handshake cycle -> pe_clr on the next cycle, busy never drops, second tile also takes 9 pe_en cycles.
- Abort: assert abort in the 5th FEED cycle (tap_k=4) -> IDLE next edge; busy=0, pe_en=0; out_valid and done never assert; a subsequent start runs a full 9-tap tile.
- Parameters FLIP=0, KDIM=2, PIPE_LAT=0: start -> 4 pe_en cycles with (win_r,win_c) = (0,0),(0,1),(1,0),(1,1); HOLD directly after the last tap.
- Async reset: assert rst mid-DRAIN between clock edges -> all outputs 0 immediately; start during HOLD is ignored; abort+start in the same cycle -> IDLE.

Source files
------------

// File: rtl/conv_tap_scheduler_if.sv
// Handshake and tap-sequencing bundle between the tile loader, the PE operand
// muxes and the result consumer of the 2x2 systolic convolution datapath.
interface conv_tap_scheduler_if;
    logic       start;
    logic       abort;
    logic       busy;
    logic       pe_clr;
    logic       pe_en;
    logic [3:0] tap_k;
    logic [1:0] tap_i;
    logic [1:0] tap_j;
    logic [1:0] win_r;
    logic [1:0] win_c;
    logic       out_valid;
    logic       out_ready;
    logic       done;

    // Loader / consumer side.
    modport master (
        output start, abort, out_ready,
        input  busy, pe_clr, pe_en, tap_k, tap_i, tap_j, win_r, win_c, out_valid, done
    );

    // Scheduler side.
    modport slave (
        input  start, abort, out_ready,
        output busy, pe_clr, pe_en, tap_k, tap_i, tap_j, win_r, win_c, out_valid, done
    );
endinterface

// File: rtl/conv_tap_scheduler.sv
// Tap sequencer for the 2x2 PE systolic convolution: clear, KDIM*KDIM feed
// cycles, fixed drain, then a valid/ready hold of the finished tile.
module conv_tap_scheduler #(
    parameter int KDIM     = 3,
    parameter int PIPE_LAT = 1,
    parameter bit FLIP     = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    conv_tap_scheduler_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        FEED  = 3'd2,
        DRAIN = 3'd3,
        HOLD  = 3'd4
    } state_e;

    localparam logic [3:0] LAST_K     = 4'(KDIM * KDIM - 1);
    localparam logic [1:0] KMAX       = 2'(KDIM - 1);
    localparam logic [1:0] DRAIN_LAST = 2'(PIPE_LAT - 1);

    state_e     state_q, state_d;
    logic [1:0] drain_q, drain_d;
    logic [3:0] tap_k_q, tap_k_d;
    logic [1:0] tap_i_q, tap_i_d;
    logic [1:0] tap_j_q, tap_j_d;
    logic [1:0] win_r_q, win_r_d;
    logic [1:0] win_c_q, win_c_d;
    logic       busy_q, busy_d;
    logic       pe_clr_q, pe_clr_d;
    logic       pe_en_q, pe_en_d;
    logic       out_valid_q, out_valid_d;
    logic       done_q, done_d;
    logic       tap_upd_s;

    // Next state, tap stepping and registered-output values.
    always_comb begin
        state_d   = state_q;
        drain_d   = drain_q;
        tap_k_d   = tap_k_q;
        tap_i_d   = tap_i_q;
        tap_j_d   = tap_j_q;
        done_d    = 1'b0;
        tap_upd_s = 1'b0;

        if (bus.abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        state_d = CLEAR;
                    end else begin
                        state_d = IDLE;
                    end
                end
                CLEAR: begin
                    state_d = FEED;
                end
                FEED: begin
                    if (tap_k_q == LAST_K) begin
                        state_d = (PIPE_LAT > 0) ? DRAIN : HOLD;
                        drain_d = 2'd0;
                    end else begin
                        tap_upd_s = 1'b1;
                        tap_k_d   = tap_k_q + 4'd1;
                        if (tap_j_q == KMAX) begin
                            tap_j_d = 2'd0;
                            tap_i_d = tap_i_q + 2'd1;
                        end else begin
                            tap_j_d = tap_j_q + 2'd1;
                        end
                    end
                end
                DRAIN: begin
                    if (drain_q == DRAIN_LAST) begin
                        state_d = HOLD;
                    end else begin
                        drain_d = drain_q + 2'd1;
                    end
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        done_d  = 1'b1;
                        state_d = bus.start ? CLEAR : IDLE;
                    end else begin
                        state_d = HOLD;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        // Taps restart from zero so the first FEED cycle sees tap 0.
        if (state_d == CLEAR) begin
            tap_upd_s = 1'b1;
            tap_k_d   = 4'd0;
            tap_i_d   = 2'd0;
            tap_j_d   = 2'd0;
        end else begin
            tap_upd_s = tap_upd_s;
        end

        if (tap_upd_s) begin
            win_r_d = FLIP ? (KMAX - tap_i_d) : tap_i_d;
            win_c_d = FLIP ? (KMAX - tap_j_d) : tap_j_d;
        end else begin
            win_r_d = win_r_q;
            win_c_d = win_c_q;
        end

        busy_d      = (state_d != IDLE);
        pe_clr_d    = (state_d == CLEAR);
        pe_en_d     = (state_d == FEED);
        out_valid_d = (state_d == HOLD);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            drain_q     <= 2'd0;
            tap_k_q     <= 4'd0;
            tap_i_q     <= 2'd0;
            tap_j_q     <= 2'd0;
            win_r_q     <= 2'd0;
            win_c_q     <= 2'd0;
            busy_q      <= 1'b0;
            pe_clr_q    <= 1'b0;
            pe_en_q     <= 1'b0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            drain_q     <= drain_d;
            tap_k_q     <= tap_k_d;
            tap_i_q     <= tap_i_d;
            tap_j_q     <= tap_j_d;
            win_r_q     <= win_r_d;
            win_c_q     <= win_c_d;
            busy_q      <= busy_d;
            pe_clr_q    <= pe_clr_d;
            pe_en_q     <= pe_en_d;
            out_valid_q <= out_valid_d;
            done_q      <= done_d;
        end
    end

    assign bus.busy      = busy_q;
    assign bus.pe_clr    = pe_clr_q;
    assign bus.pe_en     = pe_en_q;
    assign bus.tap_k     = tap_k_q;
    assign bus.tap_i     = tap_i_q;
    assign bus.tap_j     = tap_j_q;
    assign bus.win_r     = win_r_q;
    assign bus.win_c     = win_c_q;
    assign bus.out_valid = out_valid_q;
    assign bus.done      = done_q;

endmodule

// File: tb/tb_conv_tap_scheduler.sv
// Directed bench for conv_tap_scheduler: a KDIM=3/PIPE_LAT=1/FLIP=1 instance
// and a KDIM=2/PIPE_LAT=0/FLIP=0 instance sharing clock and reset.
module tb_conv_tap_scheduler;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_pass   = 0;

    conv_tap_scheduler_if if_a ();
    conv_tap_scheduler_if if_b ();

    conv_tap_scheduler #(.KDIM(3), .PIPE_LAT(1), .FLIP(1'b1)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (if_a)
    );

    conv_tap_scheduler #(.KDIM(2), .PIPE_LAT(0), .FLIP(1'b0)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (if_b)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [18:0] outs_a();
        return {if_a.busy, if_a.pe_clr, if_a.pe_en, if_a.out_valid, if_a.done,
                if_a.tap_k, if_a.tap_i, if_a.tap_j, if_a.win_r, if_a.win_c};
    endfunction

    function automatic logic [18:0] outs_b();
        return {if_b.busy, if_b.pe_clr, if_b.pe_en, if_b.out_valid, if_b.done,
                if_b.tap_k, if_b.tap_i, if_b.tap_j, if_b.win_r, if_b.win_c};
    endfunction

    // Start seen at the next edge; returns inside the CLEAR cycle.
    task automatic start_tile_a();
        if_a.start = 1'b1;
        step();
        if_a.start = 1'b0;
    endtask

    task automatic test_reset();
        if_a.start = 1'b0; if_a.abort = 1'b0; if_a.out_ready = 1'b0;
        if_b.start = 1'b0; if_b.abort = 1'b0; if_b.out_ready = 1'b0;
        rst = 1'b1;
        repeat (2) step();
        n_checks++;
        if (outs_a() !== 19'd0) $display("FAIL reset_a: got %h expected 0", outs_a());
        else n_pass++;
        n_checks++;
        if (outs_b() !== 19'd0) $display("FAIL reset_b: got %h expected 0", outs_b());
        else n_pass++;
        rst = 1'b0;
        repeat (2) step();
        n_checks++;
        if (outs_a() !== 19'd0) $display("FAIL idle_after_reset: got %h expected 0", outs_a());
        else n_pass++;
    endtask

    task automatic test_basic();
        logic [14:0] exp_v;
        if_a.out_ready = 1'b1;
        start_tile_a();
        n_checks++;
        if ({if_a.busy, if_a.pe_clr, if_a.pe_en} !== 3'b110)
            $display("FAIL basic_clear: got %b expected 110", {if_a.busy, if_a.pe_clr, if_a.pe_en});
        else n_pass++;
        for (int k = 0; k < 9; k++) begin
            step();
            exp_v = {1'b1, 4'(k), 2'(k / 3), 2'(k % 3), 2'(2 - k / 3), 2'(2 - k % 3)};
            n_checks++;
            if ({if_a.pe_en, if_a.tap_k, if_a.tap_i, if_a.tap_j, if_a.win_r, if_a.win_c} !== exp_v)
                $display("FAIL basic_tap%0d: got %h expected %h", k,
                         {if_a.pe_en, if_a.tap_k, if_a.tap_i, if_a.tap_j, if_a.win_r, if_a.win_c}, exp_v);
            else n_pass++;
        end
        step();
        n_checks++;
        if ({if_a.busy, if_a.pe_en, if_a.out_valid, if_a.tap_k} !== {3'b100, 4'd8})
            $display("FAIL basic_drain: got %h expected %h",
                     {if_a.busy, if_a.pe_en, if_a.out_valid, if_a.tap_k}, {3'b100, 4'd8});
        else n_pass++;
        step();
        n_checks++;
        if ({if_a.out_valid, if_a.busy, if_a.done} !== 3'b110)
            $display("FAIL basic_valid: got %b expected 110", {if_a.out_valid, if_a.busy, if_a.done});
        else n_pass++;
        step();
        n_checks++;
        if ({if_a.out_valid, if_a.busy, if_a.done} !== 3'b001)
            $display("FAIL basic_done: got %b expected 001", {if_a.out_valid, if_a.busy, if_a.done});
        else n_pass++;
        step();
        n_checks++;
        if ({if_a.out_valid, if_a.busy, if_a.done} !== 3'b000)
            $display("FAIL basic_done_pulse: got %b expected 000", {if_a.out_valid, if_a.busy, if_a.done});
        else n_pass++;
    endtask

    task automatic test_backpressure();
        if_a.out_ready = 1'b0;
        start_tile_a();
        repeat (11) step();
        for (int c = 0; c < 5; c++) begin
            n_checks++;
            if ({if_a.out_valid, if_a.busy, if_a.done, if_a.tap_k, if_a.win_r, if_a.win_c} !== {3'b110, 4'd8, 2'd0, 2'd0})
                $display("FAIL bp_hold%0d: got %h expected %h", c,
                         {if_a.out_valid, if_a.busy, if_a.done, if_a.tap_k, if_a.win_r, if_a.win_c},
                         {3'b110, 4'd8, 2'd0, 2'd0});
            else n_pass++;
            if (c == 4) if_a.out_ready = 1'b1;
            step();
        end
        n_checks++;
        if ({if_a.out_valid, if_a.done, if_a.busy} !== 3'b010)
            $display("FAIL bp_done: got %b expected 010", {if_a.out_valid, if_a.done, if_a.busy});
        else n_pass++;
        step();
        n_checks++;
        if (if_a.done !== 1'b0) $display("FAIL bp_done_pulse: got %b expected 0", if_a.done);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int en_cnt = 0;
        int busy_drop = 0;
        if_a.out_ready = 1'b1;
        start_tile_a();
        repeat (11) step();
        n_checks++;
        if (if_a.out_valid !== 1'b1) $display("FAIL b2b_first_valid: got %b expected 1", if_a.out_valid);
        else n_pass++;
        if_a.start = 1'b1;
        step();
        if_a.start = 1'b0;
        n_checks++;
        if ({if_a.pe_clr, if_a.busy, if_a.done, if_a.out_valid} !== 4'b1110)
            $display("FAIL b2b_clear: got %b expected 1110",
                     {if_a.pe_clr, if_a.busy, if_a.done, if_a.out_valid});
        else n_pass++;
        for (int c = 0; c < 11; c++) begin
            step();
            if (if_a.pe_en === 1'b1) en_cnt++;
            if (if_a.busy !== 1'b1) busy_drop++;
        end
        n_checks++;
        if (en_cnt != 9) $display("FAIL b2b_pe_en_count: got %0d expected 9", en_cnt);
        else n_pass++;
        n_checks++;
        if (busy_drop != 0) $display("FAIL b2b_busy_drop: got %0d expected 0", busy_drop);
        else n_pass++;
        n_checks++;
        if (if_a.out_valid !== 1'b1) $display("FAIL b2b_second_valid: got %b expected 1", if_a.out_valid);
        else n_pass++;
        step();
        n_checks++;
        if ({if_a.done, if_a.busy} !== 2'b10)
            $display("FAIL b2b_second_done: got %b expected 10", {if_a.done, if_a.busy});
        else n_pass++;
        step();
    endtask

    task automatic test_abort();
        int seen = 0;
        int en_cnt = 0;
        int v_cnt = 0;
        int d_cnt = 0;
        if_a.out_ready = 1'b1;
        start_tile_a();
        repeat (5) step();
        n_checks++;
        if ({if_a.pe_en, if_a.tap_k} !== {1'b1, 4'd4})
            $display("FAIL abort_tap4: got %h expected %h", {if_a.pe_en, if_a.tap_k}, {1'b1, 4'd4});
        else n_pass++;
        if_a.abort = 1'b1;
        step();
        if_a.abort = 1'b0;
        n_checks++;
        if ({if_a.busy, if_a.pe_en, if_a.pe_clr, if_a.out_valid, if_a.done} !== 5'b00000)
            $display("FAIL abort_idle: got %b expected 00000",
                     {if_a.busy, if_a.pe_en, if_a.pe_clr, if_a.out_valid, if_a.done});
        else n_pass++;
        for (int c = 0; c < 15; c++) begin
            step();
            if (if_a.out_valid !== 1'b0 || if_a.done !== 1'b0 || if_a.busy !== 1'b0) seen++;
        end
        n_checks++;
        if (seen != 0) $display("FAIL abort_quiet: got %0d active cycles expected 0", seen);
        else n_pass++;
        start_tile_a();
        for (int c = 0; c < 14; c++) begin
            step();
            if (if_a.pe_en === 1'b1) en_cnt++;
            if (if_a.out_valid === 1'b1) v_cnt++;
            if (if_a.done === 1'b1) d_cnt++;
        end
        n_checks++;
        if ({en_cnt, v_cnt, d_cnt} !== {32'd9, 32'd1, 32'd1})
            $display("FAIL abort_retile: got en=%0d valid=%0d done=%0d expected 9/1/1", en_cnt, v_cnt, d_cnt);
        else n_pass++;
    endtask

    task automatic test_flip0();
        logic [14:0] exp_v;
        if_b.out_ready = 1'b1;
        if_b.start = 1'b1;
        step();
        if_b.start = 1'b0;
        n_checks++;
        if ({if_b.busy, if_b.pe_clr, if_b.pe_en} !== 3'b110)
            $display("FAIL flip0_clear: got %b expected 110", {if_b.busy, if_b.pe_clr, if_b.pe_en});
        else n_pass++;
        for (int k = 0; k < 4; k++) begin
            step();
            exp_v = {1'b1, 4'(k), 2'(k / 2), 2'(k % 2), 2'(k / 2), 2'(k % 2)};
            n_checks++;
            if ({if_b.pe_en, if_b.tap_k, if_b.tap_i, if_b.tap_j, if_b.win_r, if_b.win_c} !== exp_v)
                $display("FAIL flip0_tap%0d: got %h expected %h", k,
                         {if_b.pe_en, if_b.tap_k, if_b.tap_i, if_b.tap_j, if_b.win_r, if_b.win_c}, exp_v);
            else n_pass++;
        end
        step();
        n_checks++;
        if ({if_b.pe_en, if_b.out_valid, if_b.busy} !== 3'b011)
            $display("FAIL flip0_hold: got %b expected 011", {if_b.pe_en, if_b.out_valid, if_b.busy});
        else n_pass++;
        step();
        n_checks++;
        if ({if_b.out_valid, if_b.done, if_b.busy} !== 3'b010)
            $display("FAIL flip0_done: got %b expected 010", {if_b.out_valid, if_b.done, if_b.busy});
        else n_pass++;
    endtask

    task automatic test_async_reset();
        if_a.out_ready = 1'b1;
        start_tile_a();
        repeat (10) step();
        n_checks++;
        if ({if_a.busy, if_a.pe_en, if_a.out_valid, if_a.tap_k} !== {3'b100, 4'd8})
            $display("FAIL rst_pre_drain: got %h expected %h",
                     {if_a.busy, if_a.pe_en, if_a.out_valid, if_a.tap_k}, {3'b100, 4'd8});
        else n_pass++;
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if (outs_a() !== 19'd0) $display("FAIL rst_async: got %h expected 0", outs_a());
        else n_pass++;
        #1;
        rst = 1'b0;
        repeat (3) step();
        n_checks++;
        if (outs_a() !== 19'd0) $display("FAIL rst_needs_start: got %h expected 0", outs_a());
        else n_pass++;

        if_a.out_ready = 1'b0;
        start_tile_a();
        repeat (11) step();
        if_a.start = 1'b1;
        repeat (2) step();
        n_checks++;
        if ({if_a.out_valid, if_a.busy, if_a.pe_clr, if_a.pe_en} !== 4'b1100)
            $display("FAIL hold_ignores_start: got %b expected 1100",
                     {if_a.out_valid, if_a.busy, if_a.pe_clr, if_a.pe_en});
        else n_pass++;
        if_a.abort = 1'b1;
        if_a.out_ready = 1'b1;
        step();
        if_a.abort = 1'b0;
        if_a.start = 1'b0;
        n_checks++;
        if ({if_a.busy, if_a.pe_clr, if_a.out_valid, if_a.done} !== 4'b0000)
            $display("FAIL abort_over_start: got %b expected 0000",
                     {if_a.busy, if_a.pe_clr, if_a.out_valid, if_a.done});
        else n_pass++;
        step();
        n_checks++;
        if ({if_a.busy, if_a.pe_clr, if_a.done} !== 3'b000)
            $display("FAIL abort_no_done: got %b expected 000", {if_a.busy, if_a.pe_clr, if_a.done});
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_basic();
        step();
        test_backpressure();
        step();
        test_back_to_back();
        step();
        test_abort();
        step();
        test_flip0();
        step();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
